// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch front end: credit-limited request issue, prefetch FIFO, redirect flush.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module instr_fetch_unit_chk #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = 3
) (
   input logic          clk,
   input logic          reset,
   input logic          push,
   input logic [CW-1:0] count,
   input logic [CW-1:0] outstanding
);
   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push && (count == CW'(DEPTH))));
   a_credit_bound: assert property (@(posedge clk) disable iff (reset)
      (outstanding <= CW'(DEPTH)));
endmodule

module instr_fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        instr_valid,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic [31:0] pc_next_out,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_discarded,
   output logic [31:0] perf_stall_cycles
`endif
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [31:0]   fifo_mem_r [DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] outstanding_r;
   logic [CW-1:0] discard_r;
   logic [31:0]   fetch_pc_r;
   logic [31:0]   deliver_pc_r;

   logic [CW:0]   credit_sum_s;
   logic          req_hs_s;
   logic          push_s;
   logic          pop_s;
   logic          drop_s;
   logic [31:0]   redirect_pc_s;
   logic [CW-1:0] count_nxt_s;
   logic [CW-1:0] outstanding_nxt_s;
   logic [CW-1:0] discard_nxt_s;

   // Request credit, handshake and FIFO push/pop/drop decisions.
   always_comb begin
      credit_sum_s  = {1'b0, count_r} + {1'b0, outstanding_r};
      mem_req_valid = !reset && !redirect_valid && (credit_sum_s < (CW+1)'(DEPTH));
      mem_req_addr  = fetch_pc_r;
      req_hs_s      = mem_req_valid && mem_req_ready;
      instr_valid   = (count_r != {CW{1'b0}});
      pop_s         = instr_valid && id_ready && !redirect_valid;
      // A response landing in a redirect cycle belongs to the old path.
      drop_s        = mem_rsp_valid && (redirect_valid || (discard_r != {CW{1'b0}}));
      push_s        = mem_rsp_valid && !drop_s;
      redirect_pc_s = redirect_pc & 32'hFFFF_FFFC;
      if (instr_valid) begin
         instr_out = fifo_mem_r[rd_ptr_r];
      end else begin
         instr_out = 32'h0000_0000;
      end
      pc_out      = deliver_pc_r;
      pc_next_out = deliver_pc_r + 32'd4;
   end

   // Next values of the occupancy, in-flight and discard counters.
   always_comb begin
      count_nxt_s       = count_r;
      outstanding_nxt_s = outstanding_r;
      discard_nxt_s     = discard_r;
      if (redirect_valid) begin
         count_nxt_s       = {CW{1'b0}};
         outstanding_nxt_s = outstanding_r - CW'(mem_rsp_valid);
         discard_nxt_s     = outstanding_r - CW'(mem_rsp_valid);
      end else begin
         count_nxt_s       = count_r + CW'(push_s) - CW'(pop_s);
         outstanding_nxt_s = outstanding_r + CW'(req_hs_s) - CW'(mem_rsp_valid);
         if (mem_rsp_valid && (discard_r != {CW{1'b0}})) begin
            discard_nxt_s = discard_r - CW'(1);
         end else begin
            discard_nxt_s = discard_r;
         end
      end
   end

   // Control state: PCs, pointers and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_r    <= RESET_PC;
         deliver_pc_r  <= RESET_PC;
         rd_ptr_r      <= {AW{1'b0}};
         wr_ptr_r      <= {AW{1'b0}};
         count_r       <= {CW{1'b0}};
         outstanding_r <= {CW{1'b0}};
         discard_r     <= {CW{1'b0}};
      end else begin
         count_r       <= count_nxt_s;
         outstanding_r <= outstanding_nxt_s;
         discard_r     <= discard_nxt_s;
         if (redirect_valid) begin
            fetch_pc_r   <= redirect_pc_s;
            deliver_pc_r <= redirect_pc_s;
            rd_ptr_r     <= {AW{1'b0}};
            wr_ptr_r     <= {AW{1'b0}};
         end else begin
            if (req_hs_s) begin
               fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (pop_s) begin
               deliver_pc_r <= deliver_pc_r + 32'd4;
               rd_ptr_r     <= rd_ptr_r + AW'(1);
            end
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + AW'(1);
            end
         end
      end
   end

   // FIFO storage; contents are masked by count so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= mem_rsp_data;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_drop_inc_s;

   // Dropped responses plus entries thrown away by a flush.
   always_comb begin
      if (redirect_valid) begin
         perf_drop_inc_s = 32'(drop_s) + 32'(count_r);
      end else begin
         perf_drop_inc_s = 32'(drop_s);
      end
   end

   // Free-running wrap-around event counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched      <= 32'h0000_0000;
         perf_discarded    <= 32'h0000_0000;
         perf_stall_cycles <= 32'h0000_0000;
      end else begin
         perf_fetched      <= perf_fetched + 32'(pop_s);
         perf_discarded    <= perf_discarded + perf_drop_inc_s;
         perf_stall_cycles <= perf_stall_cycles + 32'(instr_valid && !id_ready);
      end
   end
`endif

   instr_fetch_unit_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
      .clk         (clk),
      .reset       (reset),
      .push        (push_s),
      .count       (count_r),
      .outstanding (outstanding_r)
   );
endmodule
